// File: rtl/pifo_rank_pkg.sv
// pifo_rank_pkg: shared rank types and the serial-number "later" compare used by the rankers
package pifo_rank_pkg;
    localparam int RANK_W = 16;
    localparam int FLOW_W = 8;
    localparam int WEIGHT_W = 8;
    typedef logic [RANK_W-1:0] rank_t;
    typedef logic [FLOW_W-1:0] flow_id_t;
    typedef logic [WEIGHT_W-1:0] weight_t;
    // a if a is at or after b in modulo-2^w serial order, else b; operands hold w significant bits
    function automatic logic [31:0] rank_later(input logic [31:0] a, input logic [31:0] b, input int unsigned w);
        logic [31:0] d;
        d = (a - b) >> (w - 1);
        return d[0] ? b : a;
    endfunction
endpackage

// File: rtl/fallthrough_small_fifo.sv
// fallthrough_small_fifo: flop-based FIFO whose head is visible on dout without a read
module fallthrough_small_fifo #(
    parameter int WIDTH = 8,
    parameter int L2_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);
    localparam int DEPTH = 1 << L2_DEPTH;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [L2_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [L2_DEPTH:0] count;
    logic wr, rd;
    assign wr = wr_en & (count != (L2_DEPTH+1)'(DEPTH));
    assign rd = rd_en & ~empty;
    assign dout = mem[rd_ptr];
    assign empty = count == '0;
    assign nearly_full = count >= (L2_DEPTH+1)'(DEPTH - 1);
    // pointer and occupancy bookkeeping; overflowing writes and empty reads are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr] <= din;
                wr_ptr <= wr_ptr + L2_DEPTH'(1);
            end
            if (rd) rd_ptr <= rd_ptr + L2_DEPTH'(1);
            count <= count + (L2_DEPTH+1)'(wr) - (L2_DEPTH+1)'(rd);
        end
    end
endmodule

// File: rtl/wrr_rank_engine.sv
// wrr_rank_engine: per-flow weighted round-robin rank computer feeding the PIFO through an output FIFO
module wrr_rank_engine
    import pifo_rank_pkg::*;
#(
    parameter int NUM_FLOWS = 16,
    parameter int FLOW_ID_WIDTH = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int RANK_WIDTH = 16,
    parameter int META_WIDTH = 16,
    parameter int OCC_WIDTH = 8,
    parameter int L2_FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ins_valid,
    output logic                     ins_ready,
    input  logic [FLOW_ID_WIDTH-1:0] ins_flow,
    input  logic [META_WIDTH-1:0]    ins_meta,
    input  logic                     cfg_wr,
    input  logic [FLOW_ID_WIDTH-1:0] cfg_flow,
    input  logic [WEIGHT_WIDTH-1:0]  cfg_weight,
    input  logic                     dep_valid,
    input  logic [FLOW_ID_WIDTH-1:0] dep_flow,
    input  logic [RANK_WIDTH-1:0]    dep_rank,
    output logic                     out_valid,
    input  logic                     out_rd,
    output logic [RANK_WIDTH-1:0]    out_rank,
    output logic [FLOW_ID_WIDTH-1:0] out_flow,
    output logic [META_WIDTH-1:0]    out_meta,
    output logic [FLOW_ID_WIDTH:0]   active_flows,
    output logic [1:0]               err
);
    localparam int IW = $clog2(NUM_FLOWS);
    localparam int FW = FLOW_ID_WIDTH + 1;
    localparam logic [FW-1:0] NF = FW'(NUM_FLOWS);
    localparam int DW = RANK_WIDTH + FLOW_ID_WIDTH + META_WIDTH;
    logic [RANK_WIDTH-1:0] rnd [NUM_FLOWS];
    logic [WEIGHT_WIDTH-1:0] crd [NUM_FLOWS];
    logic [WEIGHT_WIDTH-1:0] wgt [NUM_FLOWS];
    logic [OCC_WIDTH-1:0] occ [NUM_FLOWS];
    logic [RANK_WIDTH-1:0] cur_round, new_r;
    logic [WEIGHT_WIDTH-1:0] new_c;
    logic [IW-1:0] fi, ci, di;
    logic ins_ok, cfg_ok, dep_ok, ins_fire, ins_do, cfg_do, dep_do, dep_err, act, adv;
    logic nearly_full, empty;
    logic [DW-1:0] head;
    assign ins_ok = {1'b0, ins_flow} < NF;
    assign cfg_ok = {1'b0, cfg_flow} < NF;
    assign dep_ok = {1'b0, dep_flow} < NF;
    assign fi = ins_flow[IW-1:0];
    assign ci = cfg_flow[IW-1:0];
    assign di = dep_flow[IW-1:0];
    assign ins_ready = ~rst & ~nearly_full & (~ins_ok | (occ[fi] != '1));
    assign ins_fire = ins_valid & ins_ready;
    assign ins_do = ins_fire & ins_ok;
    assign cfg_do = cfg_wr & cfg_ok;
    assign dep_do = dep_valid & dep_ok;
    assign dep_err = dep_do & (occ[di] == '0);
    // rank/credit for the inserting flow: rejoin at the current round, or spend credit, or advance a round
    always_comb begin
        act = occ[fi] != '0;
        adv = crd[fi] >= wgt[fi];
        new_r = ~act ? RANK_WIDTH'(rank_later(32'(rnd[fi]), 32'(cur_round), RANK_WIDTH))
              : adv ? rnd[fi] + RANK_WIDTH'(1) : rnd[fi];
        new_c = (~act | adv) ? WEIGHT_WIDTH'(1) : crd[fi] + WEIGHT_WIDTH'(1);
    end
    // per-flow and global state update; a departure from an empty flow leaves occupancy at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                rnd[i] <= '0;
                crd[i] <= '0;
                occ[i] <= '0;
                wgt[i] <= WEIGHT_WIDTH'(1);
            end
            cur_round <= '0;
            err <= '0;
        end else begin
            if (ins_do) begin
                rnd[fi] <= new_r;
                crd[fi] <= new_c;
            end
            if (cfg_do) wgt[ci] <= (cfg_weight == '0) ? WEIGHT_WIDTH'(1) : cfg_weight;
            if (dep_do) cur_round <= dep_rank;
            for (int i = 0; i < NUM_FLOWS; i++)
                occ[i] <= occ[i] + OCC_WIDTH'(ins_do && fi == IW'(i))
                                 - OCC_WIDTH'(dep_do && di == IW'(i) && occ[i] != '0);
            err <= err | {dep_err, (ins_fire & ~ins_ok) | (cfg_wr & ~cfg_ok) | (dep_valid & ~dep_ok)};
        end
    end
    // number of flows with packets outstanding downstream
    always_comb begin
        active_flows = '0;
        for (int i = 0; i < NUM_FLOWS; i++)
            active_flows = active_flows + FW'(occ[i] != '0);
    end
    fallthrough_small_fifo #(.WIDTH(DW), .L2_DEPTH(L2_FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .din({new_r, ins_flow, ins_meta}),
        .wr_en(ins_do),
        .rd_en(out_rd),
        .dout(head),
        .nearly_full(nearly_full),
        .empty(empty)
    );
    assign {out_rank, out_flow, out_meta} = head;
    assign out_valid = ~empty;
endmodule

// File: tb/tb_wrr_rank_engine.sv
// tb_wrr_rank_engine: directed checks of WRR ranking, rejoin, wrap, back-pressure, collisions and errors
module tb_wrr_rank_engine;
    logic clk = 0, rst = 1;
    logic ins_valid = 0, ins_ready, cfg_wr = 0, dep_valid = 0, out_valid, out_rd = 0;
    logic [7:0] ins_flow = 0, cfg_flow = 0, dep_flow = 0, cfg_weight = 0, out_flow;
    logic [15:0] ins_meta = 0, out_meta;
    logic [3:0] dep_rank = 0, out_rank;
    logic [8:0] active_flows;
    logic [1:0] err;
    int vec = 0, miss = 0;

    wrr_rank_engine #(.NUM_FLOWS(16), .FLOW_ID_WIDTH(8), .WEIGHT_WIDTH(8), .RANK_WIDTH(4),
                      .META_WIDTH(16), .OCC_WIDTH(8), .L2_FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_flow(ins_flow),
        .ins_meta(ins_meta), .cfg_wr(cfg_wr), .cfg_flow(cfg_flow), .cfg_weight(cfg_weight),
        .dep_valid(dep_valid), .dep_flow(dep_flow), .dep_rank(dep_rank), .out_valid(out_valid),
        .out_rd(out_rd), .out_rank(out_rank), .out_flow(out_flow), .out_meta(out_meta),
        .active_flows(active_flows), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int f, input int w);
        cfg_wr = 1; cfg_flow = 8'(f); cfg_weight = 8'(w);
        step();
        cfg_wr = 0;
    endtask

    task automatic dep(input int f, input int r);
        dep_valid = 1; dep_flow = 8'(f); dep_rank = 4'(r);
        step();
        dep_valid = 0;
    endtask

    task automatic ins_pop(input int f, input int m, input int r);
        ins_valid = 1; ins_flow = 8'(f); ins_meta = 16'(m);
        chk($sformatf("ins_ready f%0d", f), 32'(ins_ready), 1);
        step();
        ins_valid = 0;
        chk($sformatf("out_valid f%0d", f), 32'(out_valid), 1);
        chk($sformatf("out_rank f%0d m%0h", f, m), 32'(out_rank), 32'(r));
        chk($sformatf("out_flow f%0d", f), 32'(out_flow), 32'(f));
        chk($sformatf("out_meta f%0d", f), 32'(out_meta), 32'(m));
        out_rd = 1;
        step();
        out_rd = 0;
    endtask

    initial begin
        step();
        step();
        chk("rst ins_ready", 32'(ins_ready), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst active", 32'(active_flows), 0);
        chk("rst err", 32'(err), 0);
        rst = 0;
        step();
        chk("ready after rst", 32'(ins_ready), 1);

        cfg(0, 3);
        cfg(1, 1);
        for (int k = 0; k < 6; k++) begin
            ins_pop(0, 'h100 + k, k < 3 ? 0 : 1);
            ins_pop(1, 'h200 + k, k);
        end
        chk("active two flows", 32'(active_flows), 2);

        ins_pop(2, 'h300, 0);
        chk("active flow2 in", 32'(active_flows), 3);
        dep(2, 7);
        chk("active flow2 drained", 32'(active_flows), 2);
        chk("err after drain", 32'(err), 0);
        ins_pop(2, 'h301, 7);
        chk("active flow2 rejoin", 32'(active_flows), 3);

        for (int k = 0; k < 10; k++) ins_pop(3, 'h400 + k, (7 + k) % 16);
        for (int k = 0; k < 10; k++) dep(3, 15);
        chk("active flow3 drained", 32'(active_flows), 3);
        ins_pop(3, 'h40a, 0);
        chk("active flow3 rejoin", 32'(active_flows), 4);

        ins_valid = 1; ins_flow = 4; ins_meta = 'h40;
        chk("bp ready 0", 32'(ins_ready), 1);
        step();
        ins_meta = 'h41;
        chk("bp ready 1", 32'(ins_ready), 1);
        step();
        ins_meta = 'h42;
        chk("bp ready 2", 32'(ins_ready), 1);
        step();
        chk("bp nearly_full", 32'(ins_ready), 0);
        ins_meta = 'h43;
        step();
        chk("bp still stalled", 32'(ins_ready), 0);
        chk("bp head rank", 32'(out_rank), 0);
        chk("bp head meta", 32'(out_meta), 'h40);
        out_rd = 1;
        step();
        out_rd = 0;
        chk("bp ready after pop", 32'(ins_ready), 1);
        step();
        ins_valid = 0;
        chk("bp full again", 32'(ins_ready), 0);
        for (int k = 1; k < 4; k++) begin
            chk("bp drain valid", 32'(out_valid), 1);
            chk($sformatf("bp drain rank %0d", k), 32'(out_rank), 32'(k));
            chk($sformatf("bp drain meta %0d", k), 32'(out_meta), 32'('h40 + k));
            out_rd = 1;
            step();
            out_rd = 0;
        end
        chk("bp empty", 32'(out_valid), 0);

        cfg(5, 2);
        ins_pop(5, 'h500, 0);
        chk("active flow5 in", 32'(active_flows), 6);
        ins_valid = 1; ins_flow = 5; ins_meta = 'h501;
        dep_valid = 1; dep_flow = 5; dep_rank = 15;
        cfg_wr = 1; cfg_flow = 5; cfg_weight = 1;
        chk("sim ready", 32'(ins_ready), 1);
        step();
        ins_valid = 0; dep_valid = 0; cfg_wr = 0;
        chk("sim rank old weight", 32'(out_rank), 0);
        chk("sim active", 32'(active_flows), 6);
        chk("sim err", 32'(err), 0);
        out_rd = 1;
        step();
        out_rd = 0;
        ins_pop(5, 'h502, 1);
        dep(5, 15);
        dep(5, 15);
        chk("flow5 occ was 2", 32'(err), 0);
        chk("active flow5 drained", 32'(active_flows), 5);

        ins_valid = 1; ins_flow = 16; ins_meta = 'h600;
        chk("oor ready", 32'(ins_ready), 1);
        step();
        ins_valid = 0;
        chk("oor no push", 32'(out_valid), 0);
        chk("oor err0", 32'(err), 1);
        dep(9, 3);
        chk("idle dep err1", 32'(err), 3);
        chk("idle dep active", 32'(active_flows), 5);
        rst = 1;
        step();
        chk("rst clears err", 32'(err), 0);
        chk("rst clears active", 32'(active_flows), 0);
        chk("rst ready low", 32'(ins_ready), 0);
        rst = 0;
        step();
        ins_pop(5, 'h700, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/wrr_rank_engine.md
# wrr_rank_engine

Parametrised weighted round-robin rank computer for the PIFO rank pipeline. It is the successor to the fixed four-flow WRR ranker. It holds per-flow weights programmed at run time and tracks per-flow downstream occupancy, so drained flows go inactive and rejoin at the current round. It handles rank wrap-around and exposes a valid/ready insert handshake. It sits between the packet classifier and the PIFO, and buffers {rank, flow, meta} in an output FIFO until the PIFO pops it.

## Interface
- NUM_FLOWS, 16: number of tracked flows; must be a power of two ≥ 2.
- FLOW_ID_WIDTH, 8: flow id width; 2^FLOW_ID_WIDTH ≥ NUM_FLOWS.
- WEIGHT_WIDTH, 8: per-flow weight width.
- RANK_WIDTH, 16: rank (round number) width; arithmetic is modulo 2^RANK_WIDTH.
- META_WIDTH, 16: opaque metadata width.
- OCC_WIDTH, 8: per-flow outstanding-packet counter width.
- L2_FIFO_DEPTH, 4: log2 of output FIFO depth.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- ins_valid  in  1  insert request.
- ins_ready  out  1  insert accepted when ins_valid & ins_ready.
- ins_flow  in  FLOW_ID_WIDTH  flow of inserted packet.
- ins_meta  in  META_WIDTH  metadata carried with the rank.
- cfg_wr  in  1  weight write strobe.
- cfg_flow  in  FLOW_ID_WIDTH  flow whose weight is written.
- cfg_weight  in  WEIGHT_WIDTH  new weight; 0 is stored as 1.
- dep_valid  in  1  PIFO reports a packet departed.
- dep_flow  in  FLOW_ID_WIDTH  departed packet's flow.
- dep_rank  in  RANK_WIDTH  departed packet's rank; becomes the current round.
- out_valid  out  1  output FIFO non-empty.
- out_rd  in  1  pop output FIFO head; ignored when out_valid=0.
- out_rank, out_flow, out_meta  out  RANK_WIDTH / FLOW_ID_WIDTH / META_WIDTH  FIFO head.
- active_flows  out  FLOW_ID_WIDTH+1  count of flows with occupancy > 0.
- err  out  2  sticky flags: [0] out-of-range flow id, [1] departure from a flow with zero occupancy.

## Operation
- Per-flow state: round r_f (RANK_WIDTH), credit c_f (WEIGHT_WIDTH), occupancy o_f (OCC_WIDTH), weight w_f. Global state: cur_round.
- Accepted insert, flow f:
  - Inactive (o_f == 0): r_f ← later(r_f, cur_round), c_f ← 1.
  - Active, c_f == w_f: r_f ← r_f+1, c_f ← 1.
  - Otherwise: c_f ← c_f+1.
  - In all cases: push {new r_f, f, ins_meta} to the FIFO and set o_f ← o_f+1.
- later(a,b): a if (a−b) mod 2^RANK_WIDTH has MSB clear, else b (serial-number comparison). Rounds stay correct across wrap provided live ranks span < 2^(RANK_WIDTH−1).
- Departure, flow f: o_f ← o_f−1 and cur_round ← dep_rank.
  - If o_f == 0: counter holds at 0 and err[1] sets.
- active_flows tracks o_f transitions 0→1 (+1) and 1→0 (−1).
- Insert and departure on the same flow in the same cycle: o_f unchanged. The insert treats the flow as active when pre-cycle o_f > 0. If pre-cycle o_f == 0, the insert is processed as inactive and the departure raises err[1].
- cfg_wr in the same cycle as an insert to the same flow: the insert uses the old weight; the new weight applies from the next cycle. If a new weight is below the current c_f, the next insert to that flow advances the round (c_f ≥ w_f counts as equal).
- ins_flow ≥ NUM_FLOWS: the handshake completes, nothing is pushed, no state changes, err[0] sets. The same rule applies to cfg_flow/dep_flow out of range: the request is ignored and err[0] sets.
- ins_ready = ~rst & ~fifo_nearly_full & (o_f != all-ones for ins_flow).

## Timing
- Reset: ins_ready=0 while rst is high, out_valid=0, active_flows=0, err=0, all r_f=c_f=o_f=0, cur_round=0, all w_f=1.
- Reset mid-operation discards FIFO contents and all state in one cycle; ins_ready rises the cycle after rst falls.
- Insert-to-output latency is 1 cycle: a packet accepted in cycle n is visible at the FIFO head in n+1 if the FIFO was empty.
- Per-flow state is a single-cycle read-modify-write, so back-to-back inserts to the same flow need no stall and each sees the prior update.
- out_rd and an insert in the same cycle are both honoured; a full FIFO is impossible because ins_ready uses nearly_full.

## Structure
- Shared package pifo_rank_pkg holds the rank_t, flow_id_t and weight_t typedefs and the rank_later() serial-compare function. It is reused by the other rankers.
- Sub-module: the existing fallthrough_small_fifo, WIDTH = RANK_WIDTH+FLOW_ID_WIDTH+META_WIDTH.
- Per-flow state is held in flop arrays indexed by flow id; no RAM.

## Test plan
- Weights: flow 0 = 3, flow 1 = 1. Alternate inserts 0,1 ×6 → flow 0 ranks 0,0,0,1,1,1; flow 1 ranks 0,1,2,3,4,5. active_flows = 2.
- Drain and rejoin: insert flow 2 once (rank 0), then depart it with dep_rank 7 → active_flows decrements. The next flow 2 insert gets rank 7.
- Wrap, RANK_WIDTH=4: flow at r_f=15, w=1 → next rank 0. Depart rank 15, then re-activate → later(0,15) keeps 0.
- Back-pressure, L2_FIFO_DEPTH=2: insert without out_rd → ins_ready drops at nearly_full. Pop one → ins_ready returns; no packet lost or duplicated.
- Simultaneous events: insert + departure + cfg_wr on flow 5 in one cycle → o_5 unchanged, old weight used, new weight applies on the next insert.
- Errors: ins_flow = NUM_FLOWS → err[0]=1, no FIFO push. Departure on an idle flow → err[1]=1. rst clears both.
